clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller and sequencer for the programmable clock divider path.
//  Accepts divide-ratio configs via valid/ready and starts/stops the divided clock.
//  Swaps the ratio only on period boundaries (glitch-free) and counts output periods.
//  Sits between the control FSM / register block and the logic clocked by out_clk.
// PARAMETERS
//  MAX_DIV  1024  largest legal divide ratio; DW = $clog2(MAX_DIV+1)
//  CNT_W    16    width of period-count request and periods_done counter
// PORTS
//  clk           in   1      system clock
//  reset_n       in   1      asynchronous, active-low reset
//  cfg_valid     in   1      config request valid
//  cfg_ready     out  1      controller can accept config
//  cfg_div       in   DW     requested divide ratio, legal range 2..MAX_DIV
//  cfg_periods   in   CNT_W  periods to run, 0 = free-run (latched in IDLE only)
//  start         in   1      begin generating out_clk
//  stop          in   1      finish current period, then halt
//  busy          out  1      state != IDLE
//  out_clk       out  1      divided clock, registered
//  tick          out  1      high in last cycle of each out_clk period
//  periods_done  out  CNT_W  completed periods since start, saturating
//  done          out  1      1-cycle pulse on return to IDLE from a run
//  cfg_err       out  1      1-cycle pulse: illegal cfg_div or start w/o config
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, active div=0 (invalid), no pending cfg,
//   cnt=0; cfg_ready=1, busy=0, out_clk=0, tick=0, periods_done=0, done=0, cfg_err=0.
//  States: IDLE, RUN, DRAIN. Internal cnt runs 0..div-1, wraps at div-1 (boundary).
//  Config handshake: transfer when cfg_valid && cfg_ready.
//   - cfg_div <2 or >MAX_DIV: rejected, cfg_err pulses next cycle, config unchanged.
//   - IDLE: cfg_ready=1; div and cfg_periods become active next cycle.
//   - RUN: cfg_ready=1 only when no pending cfg; legal div is held pending and
//     cfg_ready drops next cycle. cfg_periods is ignored.
//   - Pending div applies at the next boundary; the current period finishes at the
//     old ratio. Pending cfg accepted in a boundary cycle applies at the following one.
//   - DRAIN: cfg_ready=0.
//  start in IDLE with valid active div: RUN next cycle, cnt=0, periods_done=0.
//   start with no valid div: ignored, cfg_err pulses. start outside IDLE: ignored.
//   start+stop same cycle in IDLE: start taken, stop ignored.
//  Waveform (RUN/DRAIN): out_clk=(cnt >= div/2), registered, no comb path from cnt.
//   Gives low floor(div/2) cycles, then high ceil(div/2) cycles.
//   tick=1 exactly when cnt==div-1, registered.
//  periods_done increments at each boundary, visible next cycle; saturates at 2^CNT_W-1.
//  cfg_periods=N>0: after the Nth boundary go to IDLE. stop in RUN: go to DRAIN, then
//   IDLE at the next boundary. stop in a boundary cycle: IDLE after that boundary.
//   stop in IDLE/DRAIN: ignored.
//  Entering IDLE from RUN/DRAIN: done=1 for one cycle; out_clk=0 and cnt=0 that cycle.
//   periods_done holds until next start. Pending cfg is applied on entry to IDLE.
//  Free-run (N=0): runs until stop or reset.
//  Reset mid-run: immediate return to reset values, active config lost.
// TESTING
//  1 cfg div=6,N=3; start -> out_clk 0x3/1x3 cycles, ticks every 6 cycles, 3 ticks;
//    done the cycle after 3rd tick; periods_done=3; busy 0.
//  2 div=5 free-run -> out_clk low 2 / high 3 cycles; stop -> clean end, done once.
//  3 div=4 free-run; at cnt=1 write div=8 -> period finishes at 4, next periods 8;
//    cfg_ready 0 until applied; 2nd write while pending is stalled.
//  4 cfg_div=1 and MAX_DIV+1 -> cfg_err, config unchanged. start after reset, no cfg
//    -> cfg_err, busy stays 0.
//  5 div=10, stop at cnt=3 -> period completes (10 cycles), done after tick.
//    stop on tick cycle -> IDLE with no extra period.
//  6 reset_n low mid-run (cnt=2) -> outputs at reset values at once; start after
//    release without cfg -> cfg_err.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: accepts divide-ratio
// configs over valid/ready, starts/stops the divided clock, swaps the ratio only
// on period boundaries and counts completed output periods.
module clk_div_ctrl #(
  parameter int unsigned MAX_DIV = 1024,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned DW     = $clog2(MAX_DIV + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DW-1:0]    cfg_div,
  input  logic [CNT_W-1:0] cfg_periods,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             out_clk,
  output logic             tick,
  output logic [CNT_W-1:0] periods_done,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [DW-1:0] DivMin = DW'(2);
  localparam logic [DW-1:0] DivMax = DW'(MAX_DIV);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [DW-1:0]    pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] pdone_q, pdone_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic cfg_legal, cfg_xfer, boundary, last_period;

  // Ready depends only on state: free in IDLE, one pending slot in RUN, closed in DRAIN.
  always_comb begin
    cfg_ready = 1'b0;
    case (state_q)
      StIdle:  cfg_ready = 1'b1;
      StRun:   cfg_ready = ~pend_q;
      default: cfg_ready = 1'b0;
    endcase
  end

  assign cfg_legal   = (cfg_div >= DivMin) && (cfg_div <= DivMax);
  assign cfg_xfer    = cfg_valid && cfg_ready;
  // Boundary is the last cycle of a period; all ratio swaps and exits happen here.
  assign boundary    = (state_q != StIdle) && (cnt_q == div_q - DW'(1));
  assign last_period = (per_q != '0) && (pdone_q == per_q - CNT_W'(1));

  // Next-state logic for the sequencer, config slots and output waveform.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    pdone_d    = pdone_q;
    done_d     = 1'b0;
    err_d      = cfg_xfer && !cfg_legal;

    case (state_q)
      StIdle: begin
        if (cfg_xfer && cfg_legal) begin
          div_d = cfg_div;
          per_d = cfg_periods;
        end
        if (start) begin
          if (div_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = '0;
            pdone_d = '0;
          end
        end
      end
      StRun, StDrain: begin
        if (boundary) begin
          cnt_d = '0;
          if (pdone_q != '1) pdone_d = pdone_q + CNT_W'(1);
          // A pending ratio lands here, including on the way back to IDLE.
          if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
          end
          if ((state_q == StDrain) || stop || last_period) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
          if ((state_q == StRun) && stop) state_d = StDrain;
        end
        // cfg_ready excludes an occupied slot, so this never races the apply above.
        if ((state_q == StRun) && cfg_xfer && cfg_legal) begin
          pend_d     = 1'b1;
          pend_div_d = cfg_div;
        end
      end
      default: state_d = StIdle;
    endcase

    // Waveform registered from next-state count so it lines up with cnt_q.
    out_clk_d = (state_d != StIdle) && (cnt_d >= (div_d >> 1));
    tick_d    = (state_d != StIdle) && (cnt_d == div_d - DW'(1));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      pdone_q    <= '0;
      out_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      pdone_q    <= pdone_d;
      out_clk_q  <= out_clk_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign out_clk      = out_clk_q;
  assign tick         = tick_q;
  assign periods_done = pdone_q;
  assign done         = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: behavioural period model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_clk_div_ctrl;

  localparam int unsigned MAX_DIV = 1024;
  localparam int unsigned CW      = 4;  // narrow counter so saturation is reachable
  localparam int unsigned DW      = $clog2(MAX_DIV + 1);
  localparam int          PD_MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [CW-1:0] cfg_periods = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_ready, busy, out_clk, tick, done, cfg_err;
  logic [CW-1:0] periods_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.MAX_DIV(MAX_DIV), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_periods  (cfg_periods),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .out_clk      (out_clk),
    .tick         (tick),
    .periods_done (periods_done),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  // Model: mode 0=idle 1=running 2=draining; pos is the position inside the period.
  int m_mode = 0, m_div = 0, m_pos = 0, m_n = 0, m_pd = 0, m_pdiv = 0;
  bit m_pend = 0, m_done = 0, m_err = 0;

  function automatic bit m_ready();
    if (m_mode == 0) return 1'b1;
    if (m_mode == 1) return !m_pend;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_div = 0; m_pos = 0; m_n = 0; m_pd = 0; m_pdiv = 0;
      m_pend = 0; m_done = 0; m_err = 0;
    end else begin
      bit xfer, legal, last;
      xfer   = cfg_valid && m_ready();
      legal  = (cfg_div >= 2) && (cfg_div <= MAX_DIV);
      last   = (m_mode != 0) && (m_pos == m_div - 1);
      m_done = 0;
      m_err  = xfer && !legal;
      if (m_mode == 0) begin
        int old_div;
        old_div = m_div;
        if (xfer && legal) begin m_div = cfg_div; m_n = cfg_periods; end
        if (start) begin
          if (old_div == 0) m_err = 1;
          else begin m_mode = 1; m_pos = 0; m_pd = 0; end
        end
      end else begin
        bit was_run, was_pend;
        was_run  = (m_mode == 1);
        was_pend = m_pend;
        if (last) begin
          int finished;
          finished = m_pd + 1;
          if (m_pd < PD_MAX) m_pd = m_pd + 1;
          m_pos = 0;
          if (was_pend) begin m_div = m_pdiv; m_pend = 0; end
          if (m_mode == 2 || stop || (m_n != 0 && finished == m_n)) begin
            m_mode = 0; m_done = 1;
          end
        end else begin
          m_pos = m_pos + 1;
          if (was_run && stop) m_mode = 2;
        end
        if (was_run && !was_pend && cfg_valid && legal) begin
          m_pend = 1; m_pdiv = cfg_div;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [CW+5:0] e, a;
    e = {m_mode != 0, (m_mode != 0) && (m_pos >= m_div / 2),
         (m_mode != 0) && (m_pos == m_div - 1), m_done, m_err, m_ready(), CW'(m_pd)};
    a = {busy, out_clk, tick, done, cfg_err, cfg_ready, periods_done};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t {busy,oclk,tick,done,err,rdy,pd} got=%b want=%b",
               $time, a, e);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from the current negedge until the next cycle with tick high.
  task automatic next_tick(input string nm, input int exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick && n < 100);
    if (!tick) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_tick want=tick t=%0t", nm, $time);
    end else begin
      chk(nm, n, exp);
    end
  endtask

  task automatic cfg(input int d, input int n);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_div = DW'(d); cfg_periods = CW'(n);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pd", periods_done, 0);
    reset_n = 1'b1;

    // Start without config, illegal ratios
    @(negedge clk);
    go();
    chk("nocfg_err", cfg_err, 1);
    chk("nocfg_busy", busy, 0);
    @(negedge clk);
    chk("err_pulse", cfg_err, 0);
    cfg(1, 0);
    chk("div1_err", cfg_err, 1);
    cfg(MAX_DIV + 1, 0);
    chk("divmax1_err", cfg_err, 1);
    go();
    chk("unchanged_err", cfg_err, 1);
    chk("unchanged_busy", busy, 0);

    // div=6, three periods
    cfg(6, 3);
    go();
    chk("t1_busy", busy, 1);
    chk("t1_low0", out_clk, 0);
    repeat (3) @(negedge clk);
    chk("t1_high3", out_clk, 1);
    next_tick("t1_tick1", 2);
    next_tick("t1_tick2", 6);
    next_tick("t1_tick3", 6);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
    chk("t1_pd", periods_done, 3);
    @(negedge clk);
    chk("t1_done_once", done, 0);

    // div=5 free-run, stop mid-period
    cfg(5, 0);
    go();
    @(negedge clk);
    chk("t2_low1", out_clk, 0);
    @(negedge clk);
    chk("t2_high2", out_clk, 1);
    next_tick("t2_tick1", 2);
    next_tick("t2_tick2", 5);
    repeat (2) @(negedge clk);
    pulse_stop();
    chk("t2_drain_busy", busy, 1);
    next_tick("t2_tick3", 2);
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_pd", periods_done, 3);
    @(negedge clk);
    chk("t2_done_once", done, 0);

    // div=4 free-run, retune to 8 at cnt=1, second write stalls while pending
    cfg(4, 0);
    go();
    @(negedge clk);
    chk("t3_ready_free", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_div = DW'(8);
    @(negedge clk);
    chk("t3_ready_pend", cfg_ready, 0);
    cfg_div = DW'(3);
    @(negedge clk);
    chk("t3_old_tick", tick, 1);
    chk("t3_ready_pend2", cfg_ready, 0);
    @(negedge clk);
    chk("t3_ready_applied", cfg_ready, 1);
    @(negedge clk);
    chk("t3_ready_again", cfg_ready, 0);
    cfg_valid = 1'b0;
    next_tick("t3_per8", 6);
    next_tick("t3_per3a", 3);
    next_tick("t3_per3b", 3);
    pulse_stop();
    chk("t3_done", done, 1);
    chk("t3_idle", busy, 0);

    // div=10: stop at cnt=3, then stop on the tick cycle
    cfg(10, 0);
    go();
    repeat (3) @(negedge clk);
    pulse_stop();
    chk("t5_busy", busy, 1);
    next_tick("t5_tick", 5);
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_pd", periods_done, 1);
    go();
    next_tick("t5b_tick", 9);
    pulse_stop();
    chk("t5b_done", done, 1);
    chk("t5b_idle", busy, 0);
    chk("t5b_pd", periods_done, 1);

    // Async reset mid-run
    cfg(7, 0);
    go();
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", cfg_ready, 1);
    chk("t6_tick", tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    go();
    chk("t6_err", cfg_err, 1);
    chk("t6_idle", busy, 0);

    // Saturation of periods_done with the narrow counter
    cfg(2, 0);
    go();
    repeat (40) @(negedge clk);
    chk("sat_pd", periods_done, PD_MAX);
    pulse_stop();
    repeat (3) @(negedge clk);
    chk("sat_idle", busy, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
